// File: rtl/eight_arbiter_mux_if.sv
// Handshake bundle for eight_arbiter_mux: eight request/data sources in, one valid/ready word out.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface eight_arbiter_mux_if #(
  parameter int DATA_WIDTH = 32
);
  logic [7:0]              req_i;
  logic [8*DATA_WIDTH-1:0] data_i;
  logic [7:0]              ack_o;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [2:0]              out_sel;

  modport master (
    input  req_i, data_i, out_ready,
    output ack_o, out_valid, out_data, out_sel
  );

  modport slave (
    output req_i, data_i, out_ready,
    input  ack_o, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/eight_arbiter_mux.sv
// 8-to-1 gathering stage: picks one requesting source per cycle and registers its word and index.
// Define EIGHT_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest index wins.
module eight_arbiter_mux #(
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  eight_arbiter_mux_if.master bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  cap;
  logic [2:0]            win;
  logic [7:0]            ack;
  logic [DATA_WIDTH-1:0] win_data;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            sel_q;

`ifdef EIGHT_ARB_ROUND_ROBIN_EN
  logic [2:0]  ptr;
  logic [2:0]  offset;
  logic [14:0] req_dbl;
  logic [7:0]  req_rot;

  // Rotating the request vector by ptr turns the circular scan into a lowest-bit search.
  assign req_dbl = {bus.req_i[6:0], bus.req_i};
  assign req_rot = req_dbl[ptr +: 8];

  always_comb begin
    offset = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) offset = 3'(k);
    end
  end

  assign win = ptr + offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= 3'd0;
    else if (cap) ptr <= win + 3'd1;
  end
`else
  always_comb begin
    win = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req_i[k]) win = 3'(k);
    end
  end
`endif

  // Nothing is taken while stalled or in reset, so ack_o can never be multi-hot or spurious.
  assign cap = (|bus.req_i) && ((state == EMPTY) || bus.out_ready) && !rst;
  assign ack = cap ? (8'h01 << win) : 8'h00;

  always_comb begin
    win_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (win == 3'(k)) win_data = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (cap) state_next = FULL;
      FULL:    if (bus.out_ready && !cap) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= 3'd0;
    end else if (cap) begin
      data_q <= win_data;
      sel_q  <= win;
    end
  end

  assign bus.ack_o     = ack;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_eight_arbiter_mux.sv
// Self-checking bench for eight_arbiter_mux: directed scenarios plus randomized traffic
// checked against a queue-free behavioural model (winner chosen by plain modulo scan).
module tb_eight_arbiter_mux;

  localparam int DW = 32;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst    = 1'b1;

  eight_arbiter_mux_if #(.DATA_WIDTH(DW)) bus();

  eight_arbiter_mux #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] src_data [8];
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            m_ptr;
  logic [7:0]    last_ack;
  logic [7:0]    pending;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int modelWinner(input logic [7:0] r);
    for (int off = 0; off < 8; off++) begin
`ifdef EIGHT_ARB_ROUND_ROBIN_EN
      int k = (m_ptr + off) % 8;
`else
      int k = off;
`endif
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // One cycle: drive at negedge, check ack before the edge, check registers after it.
  task automatic applyStimulus(input logic [7:0] r, input logic rdy);
    int         w;
    logic [7:0] eack;
    bus.req_i     = r;
    bus.out_ready = rdy;
    for (int k = 0; k < 8; k++) bus.data_i[k*DW +: DW] = src_data[k];
    #1;
    w    = modelWinner(r);
    eack = (w >= 0 && (!m_valid || rdy)) ? (8'h01 << w) : 8'h00;
    checkOutput("ack", 64'(bus.ack_o), 64'(eack));
    last_ack = eack;
    @(posedge clk);
    if (eack != 8'h00) begin
      m_valid = 1'b1;
      m_data  = src_data[w];
      m_sel   = w;
      m_ptr   = (w + 1) % 8;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("out_valid", 64'(bus.out_valid), 64'(m_valid));
    checkOutput("out_data",  64'(bus.out_data),  64'(m_data));
    checkOutput("out_sel",   64'(bus.out_sel),   64'(m_sel));
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    bus.req_i = 8'hFF;
    #1;
    checkOutput("rst_ack",   64'(bus.ack_o),     64'h0);
    checkOutput("rst_valid", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    bus.req_i     = 8'h00;
    bus.out_ready = 1'b0;
    bus.data_i    = '0;
    for (int k = 0; k < 8; k++) src_data[k] = 32'h1000_0000 + 32'(k);
    modelReset();
    @(negedge clk);
    resetDut();
    checkOutput("rst_data", 64'(bus.out_data), 64'h0);
    checkOutput("rst_sel",  64'(bus.out_sel),  64'h0);

    // Single source
    src_data[3] = 32'hDEAD_BEEF;
    applyStimulus(8'h08, 1'b1);
    checkOutput("single_valid", 64'(bus.out_valid), 64'h1);
    checkOutput("single_sel",   64'(bus.out_sel),   64'h3);
    checkOutput("single_data",  64'(bus.out_data),  64'hDEAD_BEEF);

    // All sources requesting continuously
    resetDut();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'hFF, 1'b1);
`ifdef EIGHT_ARB_ROUND_ROBIN_EN
      checkOutput("all_req_sel", 64'(bus.out_sel), 64'(i % 8));
`else
      checkOutput("all_req_sel", 64'(bus.out_sel), 64'h0);
`endif
      checkOutput("all_req_valid", 64'(bus.out_valid), 64'h1);
    end

    // Stall with requests pending
    resetDut();
    src_data[2] = 32'hCAFE_0002;
    applyStimulus(8'h04, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h90, 1'b0);
      checkOutput("stall_sel",  64'(bus.out_sel),  64'h2);
      checkOutput("stall_data", 64'(bus.out_data), 64'hCAFE_0002);
    end
    applyStimulus(8'h90, 1'b1);
    checkOutput("stall_release_sel", 64'(bus.out_sel), 64'h4);

    // Back-to-back across the pointer wrap
    resetDut();
    applyStimulus(8'h40, 1'b1);
    applyStimulus(8'h81, 1'b1);
`ifdef EIGHT_ARB_ROUND_ROBIN_EN
    checkOutput("wrap_first", 64'(bus.out_sel), 64'h7);
    applyStimulus(8'h01, 1'b1);
    checkOutput("wrap_second", 64'(bus.out_sel), 64'h0);
`else
    checkOutput("wrap_first", 64'(bus.out_sel), 64'h0);
    applyStimulus(8'h80, 1'b1);
    checkOutput("wrap_second", 64'(bus.out_sel), 64'h7);
`endif
    checkOutput("wrap_valid", 64'(bus.out_valid), 64'h1);

    // Asynchronous reset mid-transfer with the clock stopped
    resetDut();
    src_data[5] = 32'h5555_AAAA;
    applyStimulus(8'h20, 1'b0);
    checkOutput("pre_rst_sel", 64'(bus.out_sel), 64'h5);
    clk_en    = 1'b0;
    bus.req_i = 8'h20;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 64'(bus.out_valid), 64'h0);
    checkOutput("async_rst_data",  64'(bus.out_data),  64'h0);
    checkOutput("async_rst_sel",   64'(bus.out_sel),   64'h0);
    checkOutput("async_rst_ack",   64'(bus.ack_o),     64'h0);
    #2;
    rst = 1'b0;
    modelReset();
    clk_en = 1'b1;
    @(negedge clk);

    // Randomized traffic: sources hold their word until acked
    pending = 8'h00;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 8; k++) begin
        if (!pending[k] && $urandom_range(0, 2) == 0) begin
          pending[k]  = 1'b1;
          src_data[k] = $urandom;
        end
      end
      applyStimulus(pending, $urandom_range(0, 3) != 0);
      pending = pending & ~last_ack;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
